// File: rtl/apu_pkg.sv
// Shared constants for the APU tone channels: register field positions,
// length-counter load table and pulse duty patterns.
package apu_pkg;

   localparam int unsigned PERIOD_W = 11;
   localparam int unsigned LEN_W    = 8;
   localparam int unsigned VOL_W    = 4;
   localparam int unsigned SEQ_W    = 3;

   // Register indices within the channel window
   localparam int unsigned R_CTRL  = 0;
   localparam int unsigned R_SWEEP = 1;
   localparam int unsigned R_TLO   = 2;
   localparam int unsigned R_THI   = 3;

   // regs[0]: DDLC VVVV
   localparam int unsigned CTRL_HALT_BIT  = 5;
   localparam int unsigned CTRL_CONST_BIT = 4;

   // regs[1]: EPPP NSSS
   localparam int unsigned SWP_EN_BIT  = 7;
   localparam int unsigned SWP_NEG_BIT = 3;

   localparam logic [LEN_W-1:0] LEN_TABLE [32] = '{
      8'd10,  8'd254, 8'd20, 8'd2,  8'd40, 8'd4,  8'd80, 8'd6,
      8'd160, 8'd8,   8'd60, 8'd10, 8'd14, 8'd12, 8'd26, 8'd14,
      8'd12,  8'd16,  8'd24, 8'd18, 8'd48, 8'd20, 8'd96, 8'd22,
      8'd192, 8'd24,  8'd72, 8'd26, 8'd16, 8'd28, 8'd32, 8'd30
   };

   localparam logic [7:0] DUTY_TABLE [4] = '{
      8'b0000_0001, 8'b0000_0011, 8'b0000_1111, 8'b1111_1100
   };

endpackage

// File: rtl/apu_envelope.sv
// Envelope generator: quarter-frame driven decay with loop, plus constant/decay
// volume select. Shared by the pulse and noise channels.
module apu_envelope
   import apu_pkg::*;
(
   input  logic             clk,
   input  logic             n_reset,
   input  logic             qframe,
   input  logic             restart,
   input  logic             loop,
   input  logic             const_vol,
   input  logic [VOL_W-1:0] vol,
   output logic [VOL_W-1:0] level
);

   logic             env_start;
   logic [VOL_W-1:0] env_div;
   logic [VOL_W-1:0] decay;

   // Restart request is applied after the quarter-frame action so a
   // coincident qframe still sees the previous env_start.
   always_ff @(posedge clk) begin
      if (!n_reset) begin
         env_start <= 1'b0;
         env_div   <= '0;
         decay     <= '0;
      end else begin
         if (qframe) begin
            if (env_start) begin
               env_start <= 1'b0;
               decay     <= '1;
               env_div   <= vol;
            end else if (env_div == '0) begin
               env_div <= vol;
               if (decay != '0)
                  decay <= decay - VOL_W'(1);
               else if (loop)
                  decay <= '1;
            end else begin
               env_div <= env_div - VOL_W'(1);
            end
         end
         if (restart)
            env_start <= 1'b1;
      end
   end

   assign level = const_vol ? vol : decay;

endmodule

// File: rtl/apu_pulse.sv
// NES APU pulse channel: timer, duty sequencer, envelope, sweep and length
// counter producing a 4-bit sample for the mixer.
module apu_pulse
   import apu_pkg::*;
#(
   parameter int unsigned CHANNEL = 0
)
(
   input  logic                  clk,
   input  logic                  n_reset,
   input  logic [3:0][7:0]       regs,
   input  logic                  we,
   input  logic [1:0]            wr_addr,
   input  logic [7:0]            wr_data,
   input  logic                  enable,
   input  logic                  apu_tick,
   input  logic                  qframe,
   input  logic                  hframe,
   output logic [VOL_W-1:0]      out,
   output logic                  active
);

   localparam logic [PERIOD_W:0] NEG_BIAS   = (CHANNEL == 0) ? (PERIOD_W+1)'(1) : '0;
   localparam logic [PERIOD_W:0] PERIOD_MAX = {1'b0, {PERIOD_W{1'b1}}};

   logic [PERIOD_W-1:0] period;
   logic [PERIOD_W-1:0] timer;
   logic [SEQ_W-1:0]    seq;
   logic [2:0]          sweep_div;
   logic                sweep_reload;
   logic [LEN_W-1:0]    length;

   logic [PERIOD_W-1:0] delta;
   logic [PERIOD_W:0]   target;
   logic                mute;
   logic                duty_bit;
   logic                wr_swp, wr_lo, wr_hi;
   logic                swp_neg, halt;
   logic [VOL_W-1:0]    level;
   logic                unused_regs;

   assign wr_swp  = we && (wr_addr == 2'd1);
   assign wr_lo   = we && (wr_addr == 2'd2);
   assign wr_hi   = we && (wr_addr == 2'd3);
   assign swp_neg = regs[R_SWEEP][SWP_NEG_BIT];
   assign halt    = regs[R_CTRL][CTRL_HALT_BIT];

   // Timer bytes are consumed through the write path, not the bank copy.
   assign unused_regs = ^{regs[R_TLO], regs[R_THI]};

   // Sweep target and mute; pulse 1 negates in ones-complement.
   always_comb begin
      delta = period >> regs[R_SWEEP][2:0];
      if (swp_neg)
         target = {1'b0, period} - {1'b0, delta} - NEG_BIAS;
      else
         target = {1'b0, period} + {1'b0, delta};
      mute = (period < PERIOD_W'(8)) || (!swp_neg && (target > PERIOD_MAX));
   end

   always_ff @(posedge clk) begin
      if (!n_reset) begin
         period       <= '0;
         timer        <= '0;
         seq          <= '0;
         sweep_div    <= '0;
         sweep_reload <= 1'b0;
         length       <= '0;
      end else begin
         if (apu_tick) begin
            if (timer == '0) begin
               timer <= period;
               seq   <= seq - SEQ_W'(1);
            end else begin
               timer <= timer - PERIOD_W'(1);
            end
         end
         if (wr_hi)
            seq <= '0;

         // Sweep unit; a CPU period write on the same cycle takes precedence.
         if (hframe) begin
            if ((sweep_div == '0) && regs[R_SWEEP][SWP_EN_BIT] && (regs[R_SWEEP][2:0] != 3'd0)
                && !mute && !wr_lo && !wr_hi)
               period <= target[PERIOD_W-1:0];
            if ((sweep_div == '0) || sweep_reload) begin
               sweep_div    <= regs[R_SWEEP][6:4];
               sweep_reload <= 1'b0;
            end else begin
               sweep_div <= sweep_div - 3'd1;
            end
         end
         if (wr_swp)
            sweep_reload <= 1'b1;
         if (wr_lo)
            period[7:0] <= wr_data;
         if (wr_hi)
            period[PERIOD_W-1:8] <= wr_data[2:0];

         if (!enable)
            length <= '0;
         else if (wr_hi)
            length <= LEN_TABLE[wr_data[7:3]];
         else if (hframe && !halt && (length != '0))
            length <= length - LEN_W'(1);
      end
   end

   apu_envelope u_env (
      .clk       (clk),
      .n_reset   (n_reset),
      .qframe    (qframe),
      .restart   (wr_hi),
      .loop      (halt),
      .const_vol (regs[R_CTRL][CTRL_CONST_BIT]),
      .vol       (regs[R_CTRL][3:0]),
      .level     (level)
   );

   assign duty_bit = DUTY_TABLE[regs[R_CTRL][7:6]][seq];
   assign out      = ((length == '0) || mute || !duty_bit) ? '0 : level;
   assign active   = (length != '0);

endmodule

// File: tb/tb_apu_pulse.sv
// Directed bench for apu_pulse; pulse 1 and pulse 2 instances share stimulus.
module tb_apu_pulse;

   logic            clk = 1'b0;
   logic            n_reset;
   logic [3:0][7:0] regs;
   logic            we;
   logic [1:0]      wr_addr;
   logic [7:0]      wr_data;
   logic            enable, apu_tick, qframe, hframe;
   logic [3:0]      out0, out1;
   logic            active0, active1;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   apu_pulse #(.CHANNEL(0)) u_dut0 (
      .clk(clk), .n_reset(n_reset), .regs(regs), .we(we), .wr_addr(wr_addr),
      .wr_data(wr_data), .enable(enable), .apu_tick(apu_tick), .qframe(qframe),
      .hframe(hframe), .out(out0), .active(active0)
   );

   apu_pulse #(.CHANNEL(1)) u_dut1 (
      .clk(clk), .n_reset(n_reset), .regs(regs), .we(we), .wr_addr(wr_addr),
      .wr_data(wr_data), .enable(enable), .apu_tick(apu_tick), .qframe(qframe),
      .hframe(hframe), .out(out1), .active(active1)
   );

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [1:0] a, input logic [7:0] d);
      we = 1'b1; wr_addr = a; wr_data = d; regs[a] = d;
      step(1);
      we = 1'b0;
   endtask

   task automatic pulse_q(input int n);
      qframe = 1'b1; step(n); qframe = 1'b0;
   endtask

   task automatic pulse_h(input int n);
      hframe = 1'b1; step(n); hframe = 1'b0;
   endtask

   // Cycles between the first two changes of (out!=0) with apu_tick held high.
   task automatic measure(input int budget, output int c0, output int c1);
      int e0 [2];
      int e1 [2];
      int n0, n1;
      logic p0, p1;
      n0 = 0; n1 = 0; c0 = -1; c1 = -1;
      e0[0] = 0; e0[1] = 0; e1[0] = 0; e1[1] = 0;
      p0 = (out0 != 4'd0); p1 = (out1 != 4'd0);
      apu_tick = 1'b1;
      for (int i = 0; i < budget && (n0 < 2 || n1 < 2); i++) begin
         step(1);
         if (((out0 != 4'd0) != p0) && n0 < 2) begin e0[n0] = i; n0++; end
         if (((out1 != 4'd0) != p1) && n1 < 2) begin e1[n1] = i; n1++; end
         p0 = (out0 != 4'd0);
         p1 = (out1 != 4'd0);
      end
      apu_tick = 1'b0;
      if (n0 == 2) c0 = e0[1] - e0[0];
      if (n1 == 2) c1 = e1[1] - e1[0];
   endtask

   initial begin
      int c0, c1;
      logic found;

      n_reset = 1'b0; regs = '0; we = 1'b0; wr_addr = 2'd0; wr_data = 8'd0;
      enable = 1'b1; apu_tick = 1'b0; qframe = 1'b0; hframe = 1'b0;

      // Reset dominates strobes and a pending length load
      we = 1'b1; wr_addr = 2'd3; wr_data = 8'h08;
      apu_tick = 1'b1; qframe = 1'b1; hframe = 1'b1;
      step(1);
      apu_tick = 1'b0; qframe = 1'b0; hframe = 1'b1;
      step(1);
      we = 1'b0; hframe = 1'b0;
      chk("rst_out0", 16'(out0), 16'd0);
      chk("rst_active0", 16'(active0), 16'd0);
      chk("rst_out1", 16'(out1), 16'd0);
      chk("rst_active1", 16'(active1), 16'd0);
      n_reset = 1'b1;
      step(2);
      chk("post_rst_out0", 16'(out0), 16'd0);
      chk("post_rst_active0", 16'(active0), 16'd0);

      // Length load and duty 2 sequence, period 8 -> 9 ticks per step
      wr(2'd0, 8'hBF);
      wr(2'd2, 8'h08);
      wr(2'd3, 8'h08);
      chk("load_active0", 16'(active0), 16'd1);
      chk("load_out0", 16'(out0), 16'd15);
      chk("load_out1", 16'(out1), 16'd15);
      apu_tick = 1'b1;
      step(1);  chk("duty_k1", 16'(out0), 16'd0);
      step(35); chk("duty_k36", 16'(out0), 16'd0);
      step(1);  chk("duty_k37", 16'(out0), 16'd15);
      step(35); chk("duty_k72", 16'(out0), 16'd15);
      step(1);  chk("duty_k73", 16'(out0), 16'd0);
      chk("duty_k73_ch1", 16'(out1), 16'd0);
      apu_tick = 1'b0;
      enable = 1'b0;
      step(1);
      chk("disable_active0", 16'(active0), 16'd0);
      chk("disable_out0", 16'(out0), 16'd0);
      chk("disable_active1", 16'(active1), 16'd0);
      enable = 1'b1;

      // Length decrement and saturation at zero
      wr(2'd0, 8'h1F);
      wr(2'd3, 8'h18);
      chk("len2_active", 16'(active0), 16'd1);
      pulse_h(1); chk("len_h1", 16'(active0), 16'd1);
      pulse_h(1); chk("len_h2", 16'(active0), 16'd0);
      pulse_h(1); chk("len_h3", 16'(active0), 16'd0);
      chk("len_h3_out", 16'(out0), 16'd0);

      // Envelope decay V=2, no loop, then loop
      wr(2'd0, 8'h82);
      wr(2'd3, 8'h08);
      chk("env_pre", 16'(out0), 16'd0);
      pulse_q(1);  chk("env_q1", 16'(out0), 16'd15);
      pulse_q(2);  chk("env_q3", 16'(out0), 16'd15);
      pulse_q(1);  chk("env_q4", 16'(out0), 16'd14);
      pulse_q(41); chk("env_q45", 16'(out0), 16'd1);
      pulse_q(1);  chk("env_q46", 16'(out0), 16'd0);
      pulse_q(3);  chk("env_q49", 16'(out0), 16'd0);
      chk("env_q49_ch1", 16'(out1), 16'd0);
      wr(2'd0, 8'hA2);
      pulse_q(2);  chk("env_loop_q51", 16'(out0), 16'd0);
      pulse_q(1);  chk("env_loop_q52", 16'(out0), 16'd15);
      chk("env_loop_q52_ch1", 16'(out1), 16'd15);

      // Sweep negate: period 0x100, S=1 -> 0x07F (pulse 1) / 0x080 (pulse 2)
      wr(2'd0, 8'hBF);
      wr(2'd2, 8'h00);
      wr(2'd3, 8'h09);
      wr(2'd1, 8'h89);
      pulse_h(1);
      chk("swp_neg_out0", 16'(out0), 16'd15);
      measure(1500, c0, c1);
      chk("swp_neg_ch0_interval", 16'(c0), 16'd512);
      chk("swp_neg_ch1_interval", 16'(c1), 16'd516);

      // Sweep overflow mute, period left unchanged
      wr(2'd2, 8'hF0);
      wr(2'd3, 8'h0F);
      wr(2'd1, 8'h81);
      chk("mute_out0", 16'(out0), 16'd0);
      chk("mute_out1", 16'(out1), 16'd0);
      chk("mute_active0", 16'(active0), 16'd1);
      pulse_h(1);
      chk("mute_h_out0", 16'(out0), 16'd0);
      wr(2'd1, 8'h09);
      chk("unmute_out0", 16'(out0), 16'd15);
      measure(12000, c0, c1);
      chk("mute_keep_ch0_interval", 16'(c0), 16'd8132);
      chk("mute_keep_ch1_interval", 16'(c1), 16'd8132);

      // Simultaneous write/hframe/tick: load and seq reset win
      wr(2'd0, 8'h1F);
      wr(2'd2, 8'h08);
      wr(2'd3, 8'h00);
      pulse_h(5);
      chk("sim_len5_active", 16'(active0), 16'd1);
      apu_tick = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 3000 && !found; i++) begin
         step(1);
         if (out0 == 4'd0) found = 1'b1;
      end
      chk("sim_seq_align", 16'(found), 16'd1);
      step(8);
      we = 1'b1; wr_addr = 2'd3; wr_data = 8'h18; regs[3] = 8'h18; hframe = 1'b1;
      step(1);
      we = 1'b0; hframe = 1'b0; apu_tick = 1'b0;
      chk("sim_seq_reset_out0", 16'(out0), 16'd15);
      chk("sim_load_active0", 16'(active0), 16'd1);
      pulse_h(1); chk("sim_len_h1", 16'(active0), 16'd1);
      pulse_h(1); chk("sim_len_h2", 16'(active0), 16'd0);
      chk("sim_len_h2_ch1", 16'(active1), 16'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/apu_pulse.md
Name: apu_pulse

Overview:
- NES APU pulse (square) channel that sits directly downstream of the 4-byte APU register bank.
- Consumes the bank's `regs` array and CPU write events.
- Implements the timer, duty sequencer, envelope, sweep and length counter.
- Produces a 4-bit sample for the APU mixer. Two instances are used: pulse 1 and pulse 2.

Parameters:
- CHANNEL, 0, sweep negate mode: 0 = pulse 1 (ones-complement, subtract an extra 1); 1 = pulse 2 (twos-complement).

Ports:
- clk  in  1  system clock; single clock domain
- n_reset  in  1  synchronous active-low reset, sampled on posedge clk
- regs  in  4x8  register bank contents: [0] DDLC VVVV, [1] EPPP NSSS, [2] timer low, [3] LLLL Lttt
- we  in  1  one-cycle write strobe to this channel's register window
- wr_addr  in  2  register index of the write, `sys_addr[1:0]`
- wr_data  in  8  bus data of the write
- enable  in  1  channel enable bit from the status register (0x4015)
- apu_tick  in  1  one-cycle strobe every second CPU cycle; clocks the timer
- qframe  in  1  quarter-frame strobe from the frame counter
- hframe  in  1  half-frame strobe from the frame counter
- out  out  4  channel sample, 0..15
- active  out  1  length counter is nonzero

Behaviour:
- Reset (n_reset=0 at posedge): all state is cleared: period, timer, seq, env_start, env_div, decay, sweep_div, sweep_reload, length. Outputs out=0, active=0.
- All state updates on posedge clk only. Strobes are single-cycle and can coincide.
- Write side effects (we=1) use wr_data, not regs, so they take effect on the write cycle itself:
  - addr 1: sweep_reload <= 1.
  - addr 2: period[7:0] <= wr_data.
  - addr 3:
    - period[10:8] <= wr_data[2:0].
    - seq <= 0; env_start <= 1.
    - If enable=1: length <= LEN_TABLE[wr_data[7:3]].
- Timer (apu_tick=1):
  - If timer==0: timer <= period; seq <= seq-1 mod 8.
  - Else: timer <= timer-1.
  - A same-cycle addr-3 write has priority on seq.
- Duty output: bit = DUTY_TABLE[regs[0][7:6]][seq]. DUTY_TABLE rows:
  - 0: 8'b0000_0001
  - 1: 8'b0000_0011
  - 2: 8'b0000_1111
  - 3: 8'b1111_1100
- Envelope (qframe=1), with V = regs[0][3:0] and loop = regs[0][5]:
  - If env_start: env_start <= 0; decay <= 15; env_div <= V.
  - Else if env_div==0: env_div <= V; then if decay!=0, decay <= decay-1; else if loop, decay <= 15.
  - Else: env_div <= env_div-1.
  - An addr-3 write on the same cycle as qframe sets env_start; the qframe action uses the old env_start.
- Sweep target:
  - delta = period >> S.
  - target (12-bit) = period + delta, or, when N=1: period - delta - (CHANNEL==0 ? 1 : 0).
  - mute = (period < 8) | (N==0 & target > 12'h7FF).
- Sweep (hframe=1), with E, P, N, S from regs[1]:
  - If sweep_div==0 & E & S!=0 & ~mute: period <= target[10:0].
  - If sweep_div==0 | sweep_reload: sweep_div <= P; sweep_reload <= 0.
  - Else: sweep_div <= sweep_div-1.
  - A same-cycle period write wins over the sweep update.
- Length counter:
  - On hframe: if halt (regs[0][5])==0 & length!=0, length <= length-1.
  - enable=0 forces length <= 0 every cycle, overriding everything.
  - An addr-3 load on the same cycle as an hframe decrement: the load wins.
  - Length saturates at 0; it never wraps.
- Output:
  - out = 0 if length==0 | mute | duty bit==0.
  - Otherwise out = regs[0][4] ? V : decay.
  - out is combinational from registered state.
  - active = (length != 0).

Decomposition:
- Package apu_pkg holds:
  - LEN_TABLE[32] (8-bit): 10,254,20,2,40,4,80,6,160,8,60,10,14,12,26,14,12,16,24,18,48,20,96,22,192,24,72,26,16,28,32,30.
  - DUTY_TABLE[4] (8-bit).
  - Field-position constants for regs[0..3].
- Sub-module apu_envelope contains env_start/env_div/decay plus the volume select; the noise channel will reuse it.
- Sweep and timer stay inline.

Test Plan:
- Reset: hold n_reset=0 for 2 clk with strobes toggling -> out=0, active=0. After release with no writes -> still 0.
- Length and duty sequence:
  - Setup: enable=1, write r0=8'hBF (duty 2, halt, constant vol 15), r2=8'h08, r3=8'h08 (index 1 -> length 254).
  - Required: active=1, seq restarts at 0.
  - Required: out toggles between 15 and 0 with the 0000_1111 pattern, each step lasting 9 apu_ticks.
  - Then enable=0 -> active=0 and out=0 next cycle.
- Length decrement:
  - Setup: r0=8'h1F (halt=0), r3=8'h18 (index 3 -> 2).
  - Required: two hframe pulses -> active falls after the second. A third hframe keeps length at 0.
- Envelope:
  - Setup: r0=8'h82 (V=2, decay mode, no loop), write r3.
  - Required after the first qframe: out follows decay=15.
  - Required: decay decrements every 3 qframes down to 0, then holds 0.
  - With r0=8'hA2 (loop): decay reloads to 15 after reaching 0.
- Sweep negate per CHANNEL:
  - Setup: period=0x100, r1=8'h89 (E=1, P=0, N=1, S=1).
  - Required on hframe: CHANNEL=0 -> period 0x07F; CHANNEL=1 -> period 0x080.
  - Required: with N=0 and period 0x7F0, S=1 -> mute, out=0, period unchanged.
- Simultaneous events:
  - Stimulus: addr-3 write on the same cycle as hframe with length=5, halt=0.
  - Required: length = table value (not value-1). Sequencer reset wins over a same-cycle apu_tick step.
